// File: rtl/updown_seq_pkg.sv
// rtl/updown_seq_pkg.sv - shared types for the up/down count sequencer
package updown_seq_pkg;

    typedef enum logic [1:0] {
        MODE_UP_WRAP   = 2'd0,
        MODE_DOWN_WRAP = 2'd1,
        MODE_BOUNCE    = 2'd2
    } mode_t;

    localparam logic [1:0] MODE_RESERVED = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DWELL = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_HOLD = 2'd0,
        OP_LOAD = 2'd1,
        OP_INC  = 2'd2,
        OP_DEC  = 2'd3
    } step_op_t;

endpackage

// File: rtl/updown_step_unit.sv
// rtl/updown_step_unit.sv - count register with hold/load/increment/decrement control
module updown_step_unit
    import updown_seq_pkg::*;
#(
    parameter int WIDTH = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else begin
            case (op)
                OP_LOAD: count <= load_val;
                OP_INC:  count <= count + WIDTH'(1);
                OP_DEC:  count <= count - WIDTH'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/updown_count_sequencer.sv
// rtl/updown_count_sequencer.sv - bounded up/down counter controller with dwell and pass budget
module updown_count_sequencer
    import updown_seq_pkg::*;
#(
    parameter int WIDTH   = 3,
    parameter int DWELL_W = 4,
    parameter int PASS_W  = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    input  logic [WIDTH-1:0]   cfg_lo,
    input  logic [WIDTH-1:0]   cfg_hi,
    input  logic [1:0]         cfg_mode,
    input  logic [DWELL_W-1:0] cfg_dwell,
    input  logic [PASS_W-1:0]  cfg_passes,
    output logic               cfg_err,
    input  logic               start,
    input  logic               stop,
    output logic [WIDTH-1:0]   count,
    output logic               dir,
    output logic               busy,
    output logic               turn_pulse,
    output logic               done_pulse
);

    state_t             state, state_nx;
    mode_t              mode_r;
    logic [WIDTH-1:0]   lo_r, hi_r;
    logic [DWELL_W-1:0] dwell_r, dwell_cnt, dwell_nx;
    logic [PASS_W-1:0]  passes_r, pass_cnt, pass_nx, pass_inc;
    logic               dir_nx, turn_nx, done_nx, at_end, cfg_bad;
    step_op_t           op, leave_op;
    logic [WIDTH-1:0]   load_val, leave_val;
    logic               leave_dir;

    assign at_end   = dir ? (count == hi_r) : (count == lo_r);
    assign pass_inc = (&pass_cnt) ? pass_cnt : pass_cnt + PASS_W'(1);
    assign cfg_bad  = (cfg_lo > cfg_hi) || (cfg_mode == MODE_RESERVED);

    // Step taken when leaving an endpoint, either immediately or at the end of a dwell.
    always_comb begin
        leave_dir = dir;
        leave_op  = OP_LOAD;
        leave_val = lo_r;
        case (mode_r)
            MODE_UP_WRAP:   leave_val = lo_r;
            MODE_DOWN_WRAP: leave_val = hi_r;
            default: begin
                leave_dir = ~dir;
                leave_op  = (lo_r == hi_r) ? OP_HOLD : (dir ? OP_DEC : OP_INC);
            end
        endcase
    end

    always_comb begin
        state_nx = state;
        dir_nx   = dir;
        op       = OP_HOLD;
        load_val = lo_r;
        pass_nx  = pass_cnt;
        dwell_nx = dwell_cnt;
        turn_nx  = 1'b0;
        done_nx  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start && !stop) begin
                    state_nx = ST_RUN;
                    pass_nx  = '0;
                    op       = OP_LOAD;
                    if (mode_r == MODE_DOWN_WRAP) begin
                        load_val = hi_r;
                        dir_nx   = 1'b0;
                    end else begin
                        load_val = lo_r;
                        dir_nx   = 1'b1;
                    end
                end
            end
            ST_RUN: begin
                if (stop) begin
                    state_nx = ST_IDLE;
                end else if (at_end) begin
                    turn_nx = 1'b1;
                    pass_nx = pass_inc;
                    if (passes_r != '0 && pass_inc == passes_r) begin
                        state_nx = ST_IDLE;
                        done_nx  = 1'b1;
                    end else if (dwell_r != '0) begin
                        state_nx = ST_DWELL;
                        dwell_nx = dwell_r - DWELL_W'(1);
                    end else begin
                        dir_nx   = leave_dir;
                        op       = leave_op;
                        load_val = leave_val;
                    end
                end else begin
                    op = dir ? OP_INC : OP_DEC;
                end
            end
            ST_DWELL: begin
                if (stop) begin
                    state_nx = ST_IDLE;
                end else if (dwell_cnt == '0) begin
                    state_nx = ST_RUN;
                    dir_nx   = leave_dir;
                    op       = leave_op;
                    load_val = leave_val;
                end else begin
                    dwell_nx = dwell_cnt - DWELL_W'(1);
                end
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            dir        <= 1'b1;
            busy       <= 1'b0;
            cfg_ready  <= 1'b1;
            cfg_err    <= 1'b0;
            turn_pulse <= 1'b0;
            done_pulse <= 1'b0;
            lo_r       <= '0;
            hi_r       <= '1;
            mode_r     <= MODE_BOUNCE;
            dwell_r    <= '0;
            passes_r   <= '0;
            pass_cnt   <= '0;
            dwell_cnt  <= '0;
        end else begin
            state      <= state_nx;
            dir        <= dir_nx;
            busy       <= (state_nx != ST_IDLE);
            cfg_ready  <= (state_nx == ST_IDLE);
            turn_pulse <= turn_nx;
            done_pulse <= done_nx;
            pass_cnt   <= pass_nx;
            dwell_cnt  <= dwell_nx;
            cfg_err    <= cfg_valid && cfg_ready && cfg_bad;
            if (cfg_valid && cfg_ready && !cfg_bad) begin
                lo_r     <= cfg_lo;
                hi_r     <= cfg_hi;
                mode_r   <= mode_t'(cfg_mode);
                dwell_r  <= cfg_dwell;
                passes_r <= cfg_passes;
            end
        end
    end

    updown_step_unit #(.WIDTH(WIDTH)) u_step (
        .clk      (clk),
        .rst      (rst),
        .op       (op),
        .load_val (load_val),
        .count    (count)
    );

endmodule
